// File: rtl/sync_fifo_param.sv
// Parametrised first-word-fall-through synchronous FIFO with occupancy count and
// threshold flags; define SYNC_FIFO_ERR_FLAGS_EN for sticky overflow/underflow ports.
module sync_fifo_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AF_TH  = DEPTH - 1,
    parameter int unsigned AE_TH  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       datain,
    input  logic                    wr_en,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       dataout,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    output logic                    overflow,
    output logic                    underflow,
`endif
    output logic                    almost_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_TH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_TH);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    logic [DATA_W-1:0] storage_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              rd_acc, wr_acc;

    always_comb begin
        rd_acc   = rd_en && (count_q != '0);
        // A full FIFO still accepts a write when a read frees the head slot.
        wr_acc   = wr_en && ((count_q != DEPTH_C) || rd_en);
        wr_ptr_d = wr_acc ? wr_ptr_q + ONE_A : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + ONE_A : rd_ptr_q;
        count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                storage_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            // Popped slots are cleared so dataout reads 0 when empty; when full the
            // write targets the same slot and, being last, takes precedence.
            if (rd_acc) storage_q[rd_ptr_q] <= '0;
            if (wr_acc) storage_q[wr_ptr_q] <= datain;
        end
    end

    always_comb begin
        dataout      = storage_q[rd_ptr_q];
        count        = count_q;
        empty        = (count_q == '0);
        full         = (count_q == DEPTH_C);
        almost_empty = (count_q <= AE_C);
        almost_full  = (count_q >= AF_C);
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && (count_q == DEPTH_C) && !rd_en) overflow_q <= 1'b1;
            if (rd_en && (count_q == '0))                 underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised scoreboard bench for sync_fifo_param: a queue model predicts accepted
// writes and flags, a negedge monitor pops and compares every accepted read.
module tb_sync_fifo_param;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned AF_TH  = 3;
    localparam int unsigned AE_TH  = 1;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] datain = '0;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [DATA_W-1:0] dataout;
    logic [CW-1:0]     count;
    logic              empty, full, almost_empty, almost_full;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic              overflow, underflow;
`endif

    sync_fifo_param #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .AF_TH (AF_TH),
        .AE_TH (AE_TH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .datain      (datain),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .dataout     (dataout),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .almost_empty(almost_empty),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .overflow    (overflow),
        .underflow   (underflow),
`endif
        .almost_full (almost_full)
    );

    always #5 clk = ~clk;

    int              n_vec = 0;
    int              n_err = 0;
    logic [DATA_W-1:0] exp_q [$];
    int              mdl_cnt = 0;
    bit              mdl_ovf = 1'b0;
    bit              mdl_unf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        logic [DATA_W-1:0] head;
        head = '0;
        if (mdl_cnt != 0 && exp_q.size() != 0) head = exp_q[0];
        chk("count", 32'(count), 32'(mdl_cnt));
        chk("empty", 32'(empty), 32'(mdl_cnt == 0));
        chk("full", 32'(full), 32'(mdl_cnt == int'(DEPTH)));
        chk("almost_empty", 32'(almost_empty), 32'(mdl_cnt <= int'(AE_TH)));
        chk("almost_full", 32'(almost_full), 32'(mdl_cnt >= int'(AF_TH)));
        chk("dataout head", 32'(dataout), 32'(head));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("overflow", 32'(overflow), 32'(mdl_ovf));
        chk("underflow", 32'(underflow), 32'(mdl_unf));
`endif
    endtask

    // Check the state left by the previous edge, then issue one cycle of stimulus.
    task automatic drive(input bit w, input bit r, input logic [DATA_W-1:0] d);
        bit ra, wa;
        @(posedge clk);
        #1;
        check_state();
        wr_en  = w;
        rd_en  = r;
        datain = d;
        ra = r && (mdl_cnt != 0);
        wa = w && ((mdl_cnt != int'(DEPTH)) || r);
        if (w && mdl_cnt == int'(DEPTH) && !r) mdl_ovf = 1'b1;
        if (r && mdl_cnt == 0) mdl_unf = 1'b1;
        if (wa) exp_q.push_back(d);
        mdl_cnt = mdl_cnt + int'(wa) - int'(ra);
    endtask

    // Monitor: every accepted pop must return the oldest outstanding word.
    always @(negedge clk) begin
        if (rst && rd_en && !empty) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop data: got %0h, expected no data (queue empty)", dataout);
            end else begin
                chk("pop data", 32'(dataout), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1 rst = 1'b0;
        #11;
        check_state();
        @(negedge clk);
        rst = 1'b1;

        drive(1, 0, 8'h11);
        drive(1, 0, 8'h22);
        drive(1, 0, 8'h33);
        drive(1, 0, 8'h44);
        drive(1, 0, 8'h99);
        drive(1, 1, 8'h55);
        drive(1, 1, 8'h66);
        drive(1, 1, 8'h77);
        drive(1, 1, 8'h88);
        for (int i = 0; i < 5; i++) drive(0, 1, 8'h00);
        drive(1, 1, 8'hAA);
        drive(0, 1, 8'h00);
        drive(1, 0, 8'h01);
        drive(1, 0, 8'h02);
        drive(1, 0, 8'h03);

        // Asynchronous reset mid-stream, between clock edges.
        @(posedge clk);
        #3;
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b0;
        exp_q.delete();
        mdl_cnt = 0;
        mdl_ovf = 1'b0;
        mdl_unf = 1'b0;
        #1;
        check_state();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) drive(1, 0, 8'(8'hC0 + i));
        for (int i = 0; i < 4; i++) drive(0, 1, 8'h00);

        for (int i = 0; i < 800; i++) begin
            int wp;
            wp = ((i / 100) % 2 == 0) ? 75 : 25;
            drive($urandom_range(99) < wp, $urandom_range(99) < (100 - wp),
                  8'($urandom));
        end
        drive(0, 0, 8'h00);
        drive(0, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
